// File: rtl/adder_entry_seq.sv
// adder_entry_seq
// Sequencer for the Lab 1 signed 4-bit adder and its six-digit display.
// One push-button steps the user through three states. In ENTER_A the user
// enters operand A from the switches. In ENTER_B the user enters operand B.
// In SHOW the adder result is frozen and displayed.
//
// Ports
//   MAX10_CLK1_50  system clock
//   reset          synchronous, active-high reset
//   sw_in[3:0]     two's-complement operand from the slide switches
//   btn_next       asynchronous "next" button (already debounced)
//   sum[3:0]       adder sum, combinational from op_a/op_b
//   overflow       adder signed-overflow flag
//   op_a, op_b     operands driven to the adder
//   code5..code0   display codes for HEX5..HEX0
//                  (0-15 hex digit, 98 blank, 99 minus)
//   state[1:0]     0 = ENTER_A, 1 = ENTER_B, 2 = SHOW
//   result_valid   high in SHOW once the result has been captured
module adder_entry_seq #(
  parameter int BLINK_DIV = 12500000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       reset,
  input  logic [3:0] sw_in,
  input  logic       btn_next,
  input  logic [3:0] sum,
  input  logic       overflow,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [6:0] code5,
  output logic [6:0] code4,
  output logic [6:0] code3,
  output logic [6:0] code2,
  output logic [6:0] code1,
  output logic [6:0] code0,
  output logic [1:0] state,
  output logic       result_valid
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  localparam logic [6:0] CODE_BLANK = 7'd98;
  localparam logic [6:0] CODE_MINUS = 7'd99;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  state_t        state_q;
  logic          btn_s1, btn_s2, btn_prev;
  logic          press;
  logic [CW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    res_sum;
  logic          res_ovf;
  logic          captured;
  logic [3:0]    val_a, val_b;
  logic [6:0]    nxt5, nxt4, nxt3, nxt2, nxt1, nxt0;

  // A negative value shows a minus sign. A non-negative value shows a blank.
  function automatic logic [6:0] sign_code(input logic [3:0] v);
    return v[3] ? CODE_MINUS : CODE_BLANK;
  endfunction

  // Magnitude of a 4-bit two's-complement value.
  // -8 negates to 4'b1000, which reads as 8 when treated as unsigned.
  function automatic logic [6:0] mag_code(input logic [3:0] v);
    logic [3:0] m;
    m = v[3] ? (~v + 4'd1) : v;
    return {3'b000, m};
  endfunction

  // Two-flop synchroniser followed by a previous-value flop.
  // A held button gives only one rising edge, so it gives only one press.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= btn_next;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_prev;

  // Free-running blink timebase. The phase flips every BLINK_DIV cycles.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CW'(1);
    end
  end

  // Entry sequencer.
  // The first cycle in SHOW gives the external adder time to settle on the
  // new op_b, and {sum, overflow} is registered at the end of that cycle.
  // result_valid rises one edge after the capture.
  // A press always wins over the capture.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state_q      <= ENTER_A;
      op_a         <= 4'd0;
      op_b         <= 4'd0;
      res_sum      <= 4'd0;
      res_ovf      <= 1'b0;
      captured     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (press) begin
            op_a    <= sw_in;
            state_q <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (press) begin
            op_b    <= sw_in;
            state_q <= SHOW;
          end
        end
        SHOW: begin
          if (press) begin
            op_a         <= 4'd0;
            op_b         <= 4'd0;
            res_sum      <= 4'd0;
            res_ovf      <= 1'b0;
            captured     <= 1'b0;
            result_valid <= 1'b0;
            state_q      <= ENTER_A;
          end else if (!captured) begin
            res_sum  <= sum;
            res_ovf  <= overflow;
            captured <= 1'b1;
          end else begin
            result_valid <= 1'b1;
          end
        end
        default: state_q <= ENTER_A;
      endcase
    end
  end

  assign state = state_q;

  // Display source selection.
  // The operand currently being edited tracks the switches live, and blinks
  // while it is being edited. B reads as 0 until A has been entered.
  always_comb begin
    val_a = (state_q == ENTER_A) ? sw_in : op_a;
    if (state_q == ENTER_B)
      val_b = sw_in;
    else if (state_q == ENTER_A)
      val_b = 4'd0;
    else
      val_b = op_b;

    nxt5 = sign_code(val_a);
    nxt4 = mag_code(val_a);
    nxt3 = sign_code(val_b);
    nxt2 = mag_code(val_b);

    if (!blink_phase) begin
      if (state_q == ENTER_A) begin
        nxt5 = CODE_BLANK;
        nxt4 = CODE_BLANK;
      end
      if (state_q == ENTER_B) begin
        nxt3 = CODE_BLANK;
        nxt2 = CODE_BLANK;
      end
    end

    nxt1 = CODE_BLANK;
    nxt0 = CODE_BLANK;
    if (result_valid) begin
      if (res_ovf) begin
        nxt1 = 7'd0;
        nxt0 = 7'd15;
      end else begin
        nxt1 = sign_code(res_sum);
        nxt0 = mag_code(res_sum);
      end
    end
  end

  // Registered display codes, one cycle behind their sources.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      code5 <= CODE_BLANK;
      code4 <= CODE_BLANK;
      code3 <= CODE_BLANK;
      code2 <= CODE_BLANK;
      code1 <= CODE_BLANK;
      code0 <= CODE_BLANK;
    end else begin
      code5 <= nxt5;
      code4 <= nxt4;
      code3 <= nxt3;
      code2 <= nxt2;
      code1 <= nxt1;
      code0 <= nxt0;
    end
  end

endmodule

// File: tb/tb_adder_entry_seq.sv
// tb_adder_entry_seq
// Self-checking bench for adder_entry_seq.
// An external 4-bit adder is modelled next to the DUT.
// Each entered A/B pair pushes its expected display into a scoreboard queue.
// A monitor pops and compares whenever result_valid rises.
module tb_adder_entry_seq;

  logic       clk;
  logic       reset;
  logic [3:0] sw_in;
  logic       btn_next;
  logic [3:0] sum;
  logic       overflow;
  logic [3:0] op_a, op_b;
  logic [6:0] code5, code4, code3, code2, code1, code0;
  logic [1:0] state;
  logic       result_valid;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int c5, c4, c3, c2, c1, c0;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;
  int   tx_pushed   = 0;
  int   tx_seen     = 0;
  logic prev_rv     = 1'b0;

  adder_entry_seq #(.BLINK_DIV(4)) dut (
    .MAX10_CLK1_50(clk),
    .reset(reset),
    .sw_in(sw_in),
    .btn_next(btn_next),
    .sum(sum),
    .overflow(overflow),
    .op_a(op_a),
    .op_b(op_b),
    .code5(code5),
    .code4(code4),
    .code3(code3),
    .code2(code2),
    .code1(code1),
    .code0(code0),
    .state(state),
    .result_valid(result_valid)
  );

  // The Lab 1 adder that sits outside the sequencer.
  assign sum      = op_a + op_b;
  assign overflow = (op_a[3] == op_b[3]) && (sum[3] != op_a[3]);

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int to_int(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic int sign_of(input int v);
    return (v < 0) ? 99 : 98;
  endfunction

  function automatic int abs_of(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic pressBtn();
    @(negedge clk);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
  endtask

  // Enters one A/B pair, watches the SHOW handshake, then returns to ENTER_A.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int ia, ib, s;
    ia = to_int(a);
    ib = to_int(b);
    s  = ia + ib;
    e.a  = a;
    e.b  = b;
    e.c5 = sign_of(ia);
    e.c4 = abs_of(ia);
    e.c3 = sign_of(ib);
    e.c2 = abs_of(ib);
    if (s > 7 || s < -8) begin
      e.c1 = 0;
      e.c0 = 15;
    end else begin
      e.c1 = sign_of(s);
      e.c0 = abs_of(s);
    end
    sb.push_back(e);
    tx_pushed++;

    sw_in = a;
    pressBtn();
    checkOutput("state_after_a", int'(state), 1);
    repeat (3) @(negedge clk);

    sw_in = b;
    pressBtn();
    sw_in = ~b;
    checkOutput("state_after_b", int'(state), 2);
    checkOutput("rv_entry", int'(result_valid), 0);
    @(negedge clk);
    checkOutput("rv_entry_plus1", int'(result_valid), 0);
    @(negedge clk);
    checkOutput("rv_entry_plus2", int'(result_valid), 1);
    repeat (3) @(negedge clk);

    pressBtn();
    checkOutput("exit_state", int'(state), 0);
    checkOutput("exit_op_a", int'(op_a), 0);
    checkOutput("exit_op_b", int'(op_b), 0);
    checkOutput("exit_rv", int'(result_valid), 0);
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor. On each result_valid rise it checks the operands.
  // The result codes lag result_valid by one cycle, so it checks the codes
  // one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          tx_seen++;
          checkOutput("sb_op_a", int'(op_a), int'(e.a));
          checkOutput("sb_op_b", int'(op_b), int'(e.b));
          @(negedge clk);
          checkOutput("sb_code5", int'(code5), e.c5);
          checkOutput("sb_code4", int'(code4), e.c4);
          checkOutput("sb_code3", int'(code3), e.c3);
          checkOutput("sb_code2", int'(code2), e.c2);
          checkOutput("sb_code1", int'(code1), e.c1);
          checkOutput("sb_code0", int'(code0), e.c0);
        end
      end
      prev_rv = result_valid;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen_blank, seen_live;
    reset    = 1'b1;
    btn_next = 1'b0;
    sw_in    = 4'b0011;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_op_a", int'(op_a), 0);
    checkOutput("rst_op_b", int'(op_b), 0);
    checkOutput("rst_rv", int'(result_valid), 0);
    checkOutput("rst_code5", int'(code5), 98);
    checkOutput("rst_code4", int'(code4), 98);
    checkOutput("rst_code0", int'(code0), 98);

    // Idle in ENTER_A: the A pair blinks with a 4-cycle half-period.
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checkOutput("idle_code5", int'(code5), 98);
      checkOutput("idle_code4", int'(code4), ((((n - 1) / 4) % 2) == 0) ? 3 : 98);
      checkOutput("idle_code3", int'(code3), 98);
      checkOutput("idle_code2", int'(code2), 0);
      checkOutput("idle_code1", int'(code1), 98);
      checkOutput("idle_code0", int'(code0), 98);
    end

    applyStimulus(4'b0011, 4'b0010);
    applyStimulus(4'b1101, 4'b1110);
    applyStimulus(4'b0111, 4'b0001);
    applyStimulus(4'b1000, 4'b0011);
    applyStimulus(4'b1000, 4'b1000);
    for (int i = 0; i < 8; i++)
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Holding the button gives exactly one transition.
    sw_in = 4'd6;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("held_before_edge", int'(state), 0);
    @(negedge clk);
    checkOutput("held_after_edge", int'(state), 1);
    repeat (17) @(negedge clk);
    checkOutput("held_single_step", int'(state), 1);
    checkOutput("held_op_a", int'(op_a), 6);
    btn_next = 1'b0;

    // In ENTER_B, A is steady while B tracks the switches live and blinks.
    sw_in = 4'b1001;
    seen_blank = 0;
    seen_live  = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checkOutput("enter_b_code4", int'(code4), 6);
      if (code2 == 7'd98) seen_blank = 1;
      if (code2 == 7'd7 && code3 == 7'd99) seen_live = 1;
    end
    checkOutput("enter_b_blank_seen", seen_blank, 1);
    checkOutput("enter_b_live_seen", seen_live, 1);

    // Reset in the middle of ENTER_B.
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_state", int'(state), 0);
    checkOutput("mid_rst_op_a", int'(op_a), 0);
    checkOutput("mid_rst_op_b", int'(op_b), 0);
    checkOutput("mid_rst_rv", int'(result_valid), 0);
    checkOutput("mid_rst_code5", int'(code5), 98);
    checkOutput("mid_rst_code4", int'(code4), 98);
    checkOutput("mid_rst_code3", int'(code3), 98);
    checkOutput("mid_rst_code2", int'(code2), 98);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    checkOutput("sb_tx_count", tx_seen, tx_pushed);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
